// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single outstanding memory
// request, one-entry skid buffer ahead of a registered decode slot, and
// redirect handling that drains an in-flight response before refetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_8000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [ADDR_W-1:0]   tgt, tgt_n;
    logic                skid_valid, skid_valid_n;
    logic [DATA_W-1:0]   skid_instr, skid_instr_n;
    logic [ADDR_W-1:0]   skid_pc, skid_pc_n;
    logic                instr_valid_n;
    logic [DATA_W-1:0]   instr_n;
    logic [ADDR_W-1:0]   pc_out_n;

    logic                slot_free;
    logic [ADDR_W-1:0]   redirect_pc;
    logic [ADDR_W-1:0]   pc_inc;

    assign slot_free   = !instr_valid || !stall;
    assign redirect_pc = next_pc & ~ADDR_W'(3);
    assign pc_inc      = pc + ADDR_W'(PC_STEP);

    // Memory request is decoded from state; address is the outstanding pc.
    assign imem_req  = (state == S_REQ) || (state == S_DROP);
    assign imem_addr = pc;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            tgt         <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc_out      <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            tgt         <= tgt_n;
            skid_valid  <= skid_valid_n;
            skid_instr  <= skid_instr_n;
            skid_pc     <= skid_pc_n;
            instr_valid <= instr_valid_n;
            instr       <= instr_n;
            pc_out      <= pc_out_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        tgt_n         = tgt;
        skid_valid_n  = skid_valid;
        skid_instr_n  = skid_instr;
        skid_pc_n     = skid_pc;
        instr_valid_n = instr_valid;
        instr_n       = instr;
        pc_out_n      = pc_out;

        // Decode takes the slot whenever it is not stalled.
        if (instr_valid && !stall) begin
            instr_valid_n = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                state_n = S_REQ;
                if (redirect) begin
                    pc_n = redirect_pc;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_n    = redirect_pc;
                        state_n = S_REQ;
                    end else begin
                        tgt_n   = redirect_pc;
                        state_n = S_DROP;
                    end
                end else if (imem_ack) begin
                    pc_n = pc_inc;
                    if (slot_free) begin
                        instr_valid_n = 1'b1;
                        instr_n       = imem_rdata;
                        pc_out_n      = pc;
                    end else begin
                        skid_valid_n = 1'b1;
                        skid_instr_n = imem_rdata;
                        skid_pc_n    = pc;
                        state_n      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = S_REQ;
                end else if (slot_free) begin
                    instr_valid_n = 1'b1;
                    instr_n       = skid_instr;
                    pc_out_n      = skid_pc;
                    skid_valid_n  = 1'b0;
                    state_n       = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    pc_n    = redirect ? redirect_pc : tgt;
                    state_n = S_REQ;
                end else if (redirect) begin
                    tgt_n = redirect_pc;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A redirect flushes everything already fetched.
        if (redirect) begin
            instr_valid_n = 1'b0;
            skid_valid_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {instr, pc} pairs
// into a queue; a negedge monitor pops one whenever decode takes the slot.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;

    int unsigned n_pass;
    int unsigned n_total;
    logic [63:0] exp_q[$];

    fetch_unit #(
        .RESET_PC(32'h0000_8000),
        .PC_STEP (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .pc_out     (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input logic [31:0] data, input logic [31:0] addr);
        exp_q.push_back({data, addr});
    endtask

    // Monitor: score each instruction at the edge where decode consumes it.
    always @(negedge clk) begin
        if (reset && instr_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr", pc_out, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_instr", instr, e[63:32]);
                check("sb_pc", pc_out, e[31:0]);
            end
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        next_pc = '0;
        redirect = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;

        // Asynchronous reset assertion
        #3 reset = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        step();
        step();
        reset = 1'b1;
        check("idle_req", 32'(imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_8000);

        // Single-cycle ack of the first request
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        expect_instr(32'h0000_0013, 32'h0000_8000);
        step();
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instr, 32'h0000_0013);
        check("first_pc_out", pc_out, 32'h0000_8000);
        check("second_addr", imem_addr, 32'h0000_8004);

        // Stall with slot full: response goes to skid buffer
        stall = 1'b1; imem_rdata = 32'h0010_0093;
        expect_instr(32'h0010_0093, 32'h0000_8004);
        step();
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_pc_out", pc_out, 32'h0000_8000);
        imem_ack = 1'b0;
        step();
        check("hold2_req", 32'(imem_req), 32'd0);
        check("hold2_pc_out", pc_out, 32'h0000_8000);
        stall = 1'b0;
        step();
        check("unhold_pc_out", pc_out, 32'h0000_8004);
        check("unhold_req", 32'(imem_req), 32'd1);
        check("unhold_addr", imem_addr, 32'h0000_8008);
        step();
        check("drained_valid", 32'(instr_valid), 32'd0);

        // Redirect while 0x8008 is outstanding; ack arrives later
        redirect = 1'b1; next_pc = 32'h0000_9000;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drop_addr", imem_addr, 32'h0000_8008);
            check("drop_req", 32'(imem_req), 32'd1);
            check("drop_valid", 32'(instr_valid), 32'd0);
            step();
        end
        check("drop_addr", imem_addr, 32'h0000_8008);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("refetch_addr", imem_addr, 32'h0000_9000);
        check("refetch_valid", 32'(instr_valid), 32'd0);
        imem_rdata = 32'h0020_0113;
        expect_instr(32'h0020_0113, 32'h0000_9000);
        step();
        check("redir_pc_out", pc_out, 32'h0000_9000);
        check("redir_next_addr", imem_addr, 32'h0000_9004);
        imem_ack = 1'b0;
        step();

        // Redirect coincident with ack: data dropped, low bits ignored
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        redirect = 1'b1; next_pc = 32'h0000_A001;
        step();
        check("coinc_addr", imem_addr, 32'h0000_A000);
        check("coinc_valid", 32'(instr_valid), 32'd0);

        // Second redirect while draining retargets the refetch
        imem_ack = 1'b0; next_pc = 32'h0000_B000;
        step();
        check("drop2_addr", imem_addr, 32'h0000_A000);
        next_pc = 32'h0000_C003;
        step();
        check("drop2_hold_addr", imem_addr, 32'h0000_A000);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        check("retarget_addr", imem_addr, 32'h0000_C000);
        check("retarget_valid", 32'(instr_valid), 32'd0);

        // Address wrap at the top of memory
        redirect = 1'b1; next_pc = 32'hFFFF_FFFE;
        step();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_rdata = 32'h0000_0011;
        expect_instr(32'h0000_0011, 32'hFFFF_FFFC);
        step();
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        check("wrap_pc_out0", pc_out, 32'hFFFF_FFFC);
        imem_rdata = 32'h0000_0022;
        expect_instr(32'h0000_0022, 32'h0000_0000);
        step();
        check("wrap_addr2", imem_addr, 32'h0000_0004);
        check("wrap_pc_out1", pc_out, 32'h0000_0000);
        imem_ack = 1'b0;
        step();

        // Reset mid-request with a valid slot, then a late ack
        imem_ack = 1'b1; imem_rdata = 32'h0000_0044; stall = 1'b1;
        step();
        check("pre_rst_valid", 32'(instr_valid), 32'd1);
        imem_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc_out", pc_out, 32'd0);
        step();
        reset = 1'b1; stall = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        check("late_idle_req", 32'(imem_req), 32'd0);
        step();
        check("late_first_addr", imem_addr, 32'h0000_8000);
        check("late_ack_ignored", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;
        step();
        check("late_still_empty", 32'(instr_valid), 32'd0);
        check("late_addr_held", imem_addr, 32'h0000_8000);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        expect_instr(32'h0000_0033, 32'h0000_8000);
        step();
        check("post_rst_pc_out", pc_out, 32'h0000_8000);
        check("post_rst_valid", 32'(instr_valid), 32'd1);
        imem_ack = 1'b0;
        step();
        step();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h00008000, fetch address after reset.
REQ-002 Parameter PC_STEP, 4, sequential address increment in bytes.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 next_pc  input  32  redirect target from writeback stage.
REQ-006 redirect  input  1  one-cycle pulse; next_pc valid, flush and refetch.
REQ-007 stall  input  1  decode not ready; slot held when instr_valid=1.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request address, word aligned.
REQ-010 imem_ack  input  1  memory completes the request at this edge.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 instr_valid  output  1  output slot holds an instruction.
REQ-013 instr  output  32  instruction in output slot.
REQ-014 pc_out  output  32  address of instr.

Function
REQ-015 States S_IDLE, S_REQ, S_HOLD, S_DROP; all outputs registered except imem_req/imem_addr, which are decoded from state and registers only.
REQ-016 Registers: pc (outstanding/next request address), tgt (pending redirect target), 1-entry skid buffer (skid_valid, skid_instr, skid_pc), output slot.
REQ-017 Slot consumed at an edge when instr_valid=1 and stall=0; slot_free = !instr_valid || !stall.
REQ-018 imem_req=1 in S_REQ and S_DROP only; imem_addr=pc; both held stable until imem_ack sampled high.
REQ-019 imem_ack outside S_REQ/S_DROP is ignored.
REQ-020 S_IDLE: next edge -> S_REQ, pc unchanged.
REQ-021 S_REQ, ack, slot_free, no redirect: slot <= {imem_rdata, pc}, instr_valid<=1, pc<=pc+PC_STEP, stay S_REQ (back-to-back, one instruction per cycle with single-cycle ack).
REQ-022 S_REQ, ack, !slot_free, no redirect: skid <= {imem_rdata, pc}, pc<=pc+PC_STEP, -> S_HOLD.
REQ-023 S_REQ, no ack: slot drains per REQ-017 (instr_valid<=0 if consumed), stay S_REQ.
REQ-024 S_HOLD: imem_req=0; when slot_free, slot <= skid, skid_valid<=0, -> S_REQ.
REQ-025 Redirect: instr_valid<=0, skid_valid<=0 at that edge regardless of state or stall.
REQ-026 Redirect in S_IDLE, S_HOLD, or S_REQ with ack: pc<=next_pc & ~3, -> S_REQ; acked data discarded.
REQ-027 Redirect in S_REQ without ack: tgt<=next_pc & ~3, -> S_DROP; pc/addr held.
REQ-028 S_DROP: on ack, data discarded, pc<=tgt, -> S_REQ; further redirect updates tgt (same edge as ack: pc<=new next_pc & ~3).
REQ-029 Address arithmetic modulo 2^32; 32'hFFFFFFFC + PC_STEP = 32'h00000000.
REQ-030 next_pc bits[1:0] ignored (forced 0).
REQ-031 No instruction delivered twice, none skipped, none from a discarded response.

Reset
REQ-032 reset=0 immediately: state S_IDLE, pc=RESET_PC, tgt=0, skid_valid=0, instr_valid=0, instr=0, pc_out=0, imem_req=0.
REQ-033 Reset mid-request abandons it; a late ack after release is ignored per REQ-019.
REQ-034 First request (addr RESET_PC) issued in second cycle after reset release.

Verification
REQ-035 Release reset, ack 0x00000013 same cycle as first req -> imem_addr 0x8000, next edge instr_valid=1, instr=0x13, pc_out=0x8000, imem_addr=0x8004.
REQ-036 Slot full (0x8000), stall=1, ack for 0x8004 -> S_HOLD, imem_req=0, pc_out stays 0x8000; stall=0 -> pc_out=0x8004 next edge, req resumes at 0x8008.
REQ-037 redirect, next_pc=0x9000 while 0x8008 pending, ack 3 cycles later -> addr stays 0x8008 until ack, instr_valid=0 throughout, then req 0x9000, pc_out=0x9000 after its ack.
REQ-038 redirect coincident with ack of 0x8008 -> data dropped, next cycle imem_addr=0x9000.
REQ-039 redirect next_pc=0xFFFFFFFE, single-cycle acks -> addresses 0xFFFFFFFC then 0x00000000.
REQ-040 reset=0 mid-request with slot valid -> instr_valid, imem_req 0 asynchronously; post-release late ack ignored, first req 0x8000.
